instr_reader: RTL



---
 rtl/instr_register_pkg.sv | 26 ++
 rtl/instr_result_checker.sv | 32 +++
 rtl/instr_reader.sv | 102 ++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side sequencer.
// Holds opcodes, operands, the instruction bundle and the reader FSM states.
package instr_register_pkg;

   localparam int DEPTH = 32;

   typedef enum logic [2:0] {
      ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
   } opcode_t;

   typedef logic signed [31:0] operand_t;
   typedef logic signed [63:0] result_t;
   typedef logic [$clog2(DEPTH)-1:0] address_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
      result_t  res;
   } instruction_t;

   typedef enum logic [1:0] {
      IDLE, FETCH, SEND, DONE
   } reader_state_t;

endpackage

// File: rtl/instr_result_checker.sv
// Recomputes an instruction's result from opcode and operands and
// flags a stored result that disagrees. Purely combinational.
module instr_result_checker
   import instr_register_pkg::*;
(
   input  instruction_t instr,
   output logic         mismatch
);

   result_t a;
   result_t b;
   result_t expected;

   always_comb begin
      a = {{32{instr.op_a[31]}}, instr.op_a};
      b = {{32{instr.op_b[31]}}, instr.op_b};
      expected = '0;
      case (instr.opc)
         ZERO:    expected = '0;
         PASSA:   expected = a;
         PASSB:   expected = b;
         ADD:     expected = a + b;
         SUB:     expected = a - b;
         MULT:    expected = a * b;
         DIV:     expected = (b == 0) ? '0 : a / b;
         MOD:     expected = (b == 0) ? '0 : a % b;
         default: expected = '0;
      endcase
      mismatch = (expected != instr.res);
   end

endmodule

// File: rtl/instr_reader.sv
// Read-side sequencer for instr_register: walks read_pointer, streams words.
// Define INSTR_READER_CHECK_EN to compile in the result checker.
module instr_reader
   import instr_register_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  address_t          start_addr,
   input  logic [ADDR_W:0]   count,
   output address_t          read_pointer,
   input  instruction_t      instruction_word,
   output logic              out_valid,
   input  logic              out_ready,
   output instruction_t      out_instr,
   output logic              out_mismatch,
   output logic [ADDR_W:0]   err_count,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ERR_MAX = '1;
   localparam address_t        LAST    = address_t'(DEPTH - 1);

   reader_state_t   state;
   logic [ADDR_W:0] remaining;
   logic            chk_mis;

`ifdef INSTR_READER_CHECK_EN
   instr_result_checker u_chk (
      .instr    (instruction_word),
      .mismatch (chk_mis)
   );
`else
   assign chk_mis = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         read_pointer <= '0;
         remaining    <= '0;
         out_valid    <= 1'b0;
         out_instr    <= '0;
         out_mismatch <= 1'b0;
         err_count    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  read_pointer <= start_addr;
                  remaining    <= (count > MAX_CNT) ? MAX_CNT : count;
                  err_count    <= '0;
                  busy         <= 1'b1;
                  if (count == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            FETCH: begin
               out_instr    <= instruction_word;
               out_mismatch <= chk_mis;
               out_valid    <= 1'b1;
               state        <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  remaining <= remaining - 1'b1;
                  if (out_mismatch && err_count != ERR_MAX)
                     err_count <= err_count + 1'b1;
                  if (remaining == 1) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     // Pointer wraps at the top of the register file
                     read_pointer <= (read_pointer == LAST) ?
                                     '0 : read_pointer + 1'b1;
                     state        <= FETCH;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
